phase_acc_bank: RTL
===================

# phase_acc_bank

Per-operator phase accumulator bank for the OPL2 core, directly upstream of rhythm phase calculation. Holds one 20-bit phase accumulator for each of the 18 operator slots. On each operator strobe it:
- advances the selected slot by its phase increment, or restarts it on key-on;
- presents the slot's current phase;
- keeps snapshots of slots 13 and 17, which the hi-hat and top-cymbal phase logic consume.

## Interface
Parameters:
- NUM_OPERATORS, 18, operator slots held in the bank
- HI_HAT_SLOT, 13, slot whose phase is snapshotted to phase_acc_13
- TOP_CYMBAL_SLOT, 17, slot whose phase is snapshotted to phase_acc_17

Ports:
- clk  input  1  core clock, single clock domain
- rst  input  1  asynchronous, active-high reset
- op_en  input  1  one-cycle strobe: process slot op_num this cycle
- op_num  input  `OP_NUM_WIDTH  slot index, sampled with op_en
- phase_inc  input  `PHASE_ACC_WIDTH  increment for this slot (fnum/block/mult/vibrato already applied upstream)
- key_on_pulse  input  1  sampled with op_en: restart this slot's phase
- phase_acc  output  `PHASE_ACC_WIDTH  current phase of the processed slot, registered
- phase_valid  output  1  one-cycle strobe, phase_acc/op_num_out valid
- op_num_out  output  `OP_NUM_WIDTH  slot index aligned with phase_acc
- phase_acc_13  output  `PHASE_ACC_WIDTH  last phase presented for HI_HAT_SLOT
- phase_acc_17  output  `PHASE_ACC_WIDTH  last phase presented for TOP_CYMBAL_SLOT

## Operation
- Storage: acc[0..17], each `PHASE_ACC_WIDTH` bits, in flops, all cleared by rst.
- Normal strobe: op_en=1, op_num<18, key_on_pulse=0.
  - phase_acc <= acc[op_num], the pre-increment value.
  - acc[op_num] <= acc[op_num] + phase_inc, modulo 2^`PHASE_ACC_WIDTH`. The carry is dropped; wrap-around is silent.
- Key-on strobe: op_en=1, op_num<18, key_on_pulse=1.
  - phase_acc <= 0.
  - acc[op_num] <= phase_inc, so the first sample after key-on is phase 0 and the next is phase_inc.
- Snapshots: when the processed slot equals HI_HAT_SLOT (or TOP_CYMBAL_SLOT), the matching snapshot register loads the same value as phase_acc, in the same cycle.
- Snapshot ordering: slot 13 is processed before slot 17 in a sample. The hi-hat therefore sees slot 17's phase from the previous sample. This is intended.
- Out-of-range op_num (≥18) with op_en:
  - no accumulator or snapshot change;
  - phase_valid stays 0;
  - phase_acc holds its value.
- op_en=0: no state change, phase_valid=0, all outputs hold.
- key_on_pulse and phase_inc are ignored when op_en=0.

## Timing
- Latency: 1 cycle. The op_en strobe at edge N produces phase_valid, phase_acc and op_num_out at edge N+1.
- Throughput: one slot per cycle. Back-to-back strobes are allowed.
- Same op_num on consecutive cycles: the second strobe sees the already-updated accumulator (read-modify-write completes within the cycle, so there is no hazard).
- Reset: asynchronous assert.
  - Asserting rst mid-sequence clears every accumulator and snapshot immediately.
  - All outputs go to 0 while rst is high: phase_acc, phase_acc_13, phase_acc_17, op_num_out, phase_valid.
  - First strobe after deassert: takes effect at the next rising edge, reads 0.
- No internal state machine beyond the accumulator array and output registers. Slot sequencing is owned by the upstream operator sequencer.

## Structure
- opl.vh holds:
  - `PHASE_ACC_WIDTH (20)
  - `OP_NUM_WIDTH (5)
  - `NUM_OPERATORS (18)
  - slot constants `HI_HAT_SLOT (13) and `TOP_CYMBAL_SLOT (17), used both here and by the rhythm phase stage.
- Single module, no sub-modules.
- The accumulator array is a reg array indexed by op_num. It is not inferred RAM, because every entry must clear on asynchronous reset.
- The outputs phase_acc, phase_acc_13 and phase_acc_17 feed the rhythm phase stage directly.

## Test plan
- Reset, then strobe slot 0 with phase_inc=0x00100 three times → phase_acc = 0x00000, 0x00100, 0x00200; phase_valid high exactly one cycle after each strobe.
- Wrap-around on slot 5:
  - setup: preload to 0xFFF80 via repeated strobes;
  - stimulus: strobe with phase_inc=0x00100;
  - response: phase_acc=0xFFF80, and the next strobe gives 0x00080.
- Key-on on slot 2 after accumulation to 0x12345, with phase_inc=0x00040 → phase_acc=0x00000, then 0x00040 on the next strobe.
- Snapshots:
  - stimulus: process slots 13 and 17 with distinct increments;
  - response: phase_acc_13 and phase_acc_17 each equal the value presented for that slot;
  - check: both snapshots are unchanged when any other slot is strobed.
- op_num=20 with op_en → phase_valid stays 0 and no accumulator changes (confirmed by re-reading all 18 slots).
- Reset mid-run:
  - stimulus: assert rst asynchronously between edges during a strobe burst;
  - response: outputs go to 0 immediately;
  - after deassert: every slot reads 0 on its first strobe.

Source files
------------

// File: rtl/phase_acc_bank_pkg.sv
// Shared widths, slot constants and helpers for the OPL2 operator phase
// accumulator bank and the rhythm phase stage that consumes its outputs.
package phase_acc_bank_pkg;

  localparam int PHASE_ACC_WIDTH         = 20;
  localparam int OP_NUM_WIDTH            = 5;
  localparam int NUM_OPERATORS_DEFAULT   = 18;
  localparam int HI_HAT_SLOT_DEFAULT     = 13;
  localparam int TOP_CYMBAL_SLOT_DEFAULT = 17;

  typedef logic [PHASE_ACC_WIDTH-1:0] phase_t;
  typedef logic [OP_NUM_WIDTH-1:0]    op_num_t;

  // Value an accumulator holds after being processed: a key-on restarts the
  // slot so that the next presented phase is exactly the increment, otherwise
  // the increment is added and any carry out of the top bit is discarded.
  function automatic phase_t next_acc(input phase_t cur, input phase_t inc,
                                      input logic key_on);
    phase_t result;
    if (key_on) begin
      result = inc;
    end else begin
      result = cur + inc;
    end
    return result;
  endfunction

  // Value presented on the output for a processed slot: the pre-increment
  // phase, or zero on the key-on sample.
  function automatic phase_t presented_phase(input phase_t cur, input logic key_on);
    phase_t result;
    if (key_on) begin
      result = '0;
    end else begin
      result = cur;
    end
    return result;
  endfunction

endpackage

// File: rtl/phase_acc_bank_if.sv
// Operator strobe request and phase result bundle between the operator
// sequencer (master) and the phase accumulator bank (slave).
interface phase_acc_bank_if;
  import phase_acc_bank_pkg::*;

  logic    op_en;
  op_num_t op_num;
  phase_t  phase_inc;
  logic    key_on_pulse;

  phase_t  phase_acc;
  logic    phase_valid;
  op_num_t op_num_out;
  phase_t  phase_acc_13;
  phase_t  phase_acc_17;

  modport master (
    output op_en,
    output op_num,
    output phase_inc,
    output key_on_pulse,
    input  phase_acc,
    input  phase_valid,
    input  op_num_out,
    input  phase_acc_13,
    input  phase_acc_17
  );

  modport slave (
    input  op_en,
    input  op_num,
    input  phase_inc,
    input  key_on_pulse,
    output phase_acc,
    output phase_valid,
    output op_num_out,
    output phase_acc_13,
    output phase_acc_17
  );

endinterface

// File: rtl/phase_acc_bank.sv
// Per-operator phase accumulator bank. Each strobed slot presents its current
// phase one cycle later and advances (or restarts on key-on) in the same
// cycle. The hi-hat and top-cymbal slots additionally keep a snapshot of the
// last phase they presented for the rhythm phase stage.
module phase_acc_bank
  import phase_acc_bank_pkg::*;
#(
  parameter int NUM_OPERATORS   = NUM_OPERATORS_DEFAULT,
  parameter int HI_HAT_SLOT     = HI_HAT_SLOT_DEFAULT,
  parameter int TOP_CYMBAL_SLOT = TOP_CYMBAL_SLOT_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  phase_acc_bank_if.slave bus
);

  // Accumulators live in flops rather than RAM so every slot clears on reset.
  phase_t  acc [NUM_OPERATORS];

  logic    slot_hit;
  phase_t  cur_phase;
  phase_t  out_phase;
  phase_t  upd_phase;

  phase_t  phase_acc_q;
  logic    phase_valid_q;
  op_num_t op_num_out_q;
  phase_t  snap_hi_hat_q;
  phase_t  snap_top_cymbal_q;

  // Decode the strobe and select the addressed slot; out-of-range indices
  // never hit, so they leave all state untouched.
  always_comb begin
    slot_hit  = bus.op_en && (bus.op_num < OP_NUM_WIDTH'(NUM_OPERATORS));
    cur_phase = '0;
    for (int i = 0; i < NUM_OPERATORS; i++) begin
      if (bus.op_num == OP_NUM_WIDTH'(i)) begin
        cur_phase = acc[i];
      end
    end
    out_phase = presented_phase(cur_phase, bus.key_on_pulse);
    upd_phase = next_acc(cur_phase, bus.phase_inc, bus.key_on_pulse);
  end

  // Read-modify-write of the addressed accumulator; a repeat strobe of the
  // same slot next cycle naturally sees the updated value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_OPERATORS; i++) begin
        acc[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_OPERATORS; i++) begin
        if (slot_hit && (bus.op_num == OP_NUM_WIDTH'(i))) begin
          acc[i] <= upd_phase;
        end
      end
    end
  end

  // Registered result: valid pulses for one cycle per accepted strobe while
  // phase and slot index hold until the next accepted strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_acc_q   <= '0;
      phase_valid_q <= 1'b0;
      op_num_out_q  <= '0;
    end else begin
      phase_valid_q <= slot_hit;
      if (slot_hit) begin
        phase_acc_q  <= out_phase;
        op_num_out_q <= bus.op_num;
      end
    end
  end

  // Rhythm snapshots load alongside the presented phase for their slot only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_hi_hat_q     <= '0;
      snap_top_cymbal_q <= '0;
    end else begin
      if (slot_hit && (bus.op_num == OP_NUM_WIDTH'(HI_HAT_SLOT))) begin
        snap_hi_hat_q <= out_phase;
      end
      if (slot_hit && (bus.op_num == OP_NUM_WIDTH'(TOP_CYMBAL_SLOT))) begin
        snap_top_cymbal_q <= out_phase;
      end
    end
  end

  assign bus.phase_acc    = phase_acc_q;
  assign bus.phase_valid  = phase_valid_q;
  assign bus.op_num_out   = op_num_out_q;
  assign bus.phase_acc_13 = snap_hi_hat_q;
  assign bus.phase_acc_17 = snap_top_cymbal_q;

endmodule
